// File: rtl/gpio_led_ctrl.sv
// Memory-mapped LED/button peripheral: OUT/SET/CLR/TOG LED latch with hardware blink,
// debounced buttons with sticky rising-edge flags and a maskable level interrupt.
module gpio_led_ctrl #(
    parameter int NUM_LEDS        = 8,
    parameter int NUM_BTNS        = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_DIV_W     = 16
) (
    input  logic                original_clk,
    input  logic                rst,
    input  logic [2:0]          bus_addr,
    input  logic [31:0]         bus_wdata,
    input  logic                bus_we,
    input  logic                bus_re,
    output logic [31:0]         bus_rdata,
    output logic                bus_rvalid,
    input  logic [NUM_BTNS-1:0] btn,
    output logic [NUM_LEDS-1:0] leds,
    output logic                irq
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_LEDS-1:0]    out_q, out_d, blink_en_q, blink_en_d, leds_q;
    logic [BLINK_DIV_W-1:0] blink_div_q, blink_div_d, presc_q, presc_d;
    logic                   phase_q, phase_d;
    logic [NUM_BTNS-1:0]    meta_q, sync_q, stable_q, stable_d, edge_q, edge_d;
    logic [DB_W-1:0]        db_cnt_q [NUM_BTNS];
    logic [DB_W-1:0]        db_cnt_d [NUM_BTNS];
    logic                   irq_q, rvalid_q;
    logic [31:0]            rdata_q, rdata_d, edge_word_s;
    logic [NUM_BTNS-1:0]    irq_en_s, edge_clr_s;
    logic [NUM_LEDS-1:0]    wd_led_s;
    logic                   wr_edge_s;
    logic                   unused_s;

    assign wd_led_s   = bus_wdata[NUM_LEDS-1:0];
    assign wr_edge_s  = bus_we && (bus_addr == 3'd7);
    assign edge_clr_s = wr_edge_s ? bus_wdata[NUM_BTNS-1:0] : {NUM_BTNS{1'b0}};
    assign unused_s   = ^bus_wdata;

    // LED register file updates from bus writes
    always_comb begin
        out_d       = out_q;
        blink_en_d  = blink_en_q;
        blink_div_d = blink_div_q;
        if (bus_we) begin
            case (bus_addr)
                3'd0:    out_d       = wd_led_s;
                3'd1:    out_d       = out_q | wd_led_s;
                3'd2:    out_d       = out_q & ~wd_led_s;
                3'd3:    out_d       = out_q ^ wd_led_s;
                3'd4:    blink_en_d  = wd_led_s;
                3'd5:    blink_div_d = bus_wdata[BLINK_DIV_W-1:0];
                default: out_d       = out_q;
            endcase
        end else begin
            out_d = out_q;
        end
    end

    // Blink prescaler; a BLINK_DIV write restarts the count without touching the phase
    always_comb begin
        presc_d = presc_q;
        phase_d = phase_q;
        if (bus_we && (bus_addr == 3'd5)) begin
            presc_d = {BLINK_DIV_W{1'b0}};
        end else if (presc_q == blink_div_q) begin
            presc_d = {BLINK_DIV_W{1'b0}};
            phase_d = ~phase_q;
        end else begin
            presc_d = presc_q + BLINK_DIV_W'(1);
        end
    end

    // Per-button debounce: stable follows sync only after DEBOUNCE_CYCLES differing cycles
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (sync_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync_q[i];
                    db_cnt_d[i] = {DB_W{1'b0}};
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end else begin
                db_cnt_d[i] = {DB_W{1'b0}};
            end
        end
        // A fresh rise beats a simultaneous W1C of the same bit
        edge_d = (edge_q & ~edge_clr_s) | (stable_d & ~stable_q);
    end

    // Read mux samples pre-write state, so a same-cycle write is not visible
    always_comb begin
        rdata_d = rdata_q;
        if (bus_re) begin
            case (bus_addr)
                3'd0:    rdata_d = 32'(out_q);
                3'd4:    rdata_d = 32'(blink_en_q);
                3'd5:    rdata_d = 32'(blink_div_q);
                3'd6:    rdata_d = 32'(stable_q);
                3'd7:    rdata_d = edge_word_s;
                default: rdata_d = 32'h0000_0000;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    generate
        if (NUM_BTNS <= 16) begin : g_irq_en
            logic [NUM_BTNS-1:0] irq_en_q;
            // IRQ_EN lives in the upper half of the EDGE word
            always_ff @(posedge original_clk) begin
                if (!rst) begin
                    irq_en_q <= {NUM_BTNS{1'b0}};
                end else if (wr_edge_s) begin
                    irq_en_q <= bus_wdata[16 +: NUM_BTNS];
                end else begin
                    irq_en_q <= irq_en_q;
                end
            end
            assign irq_en_s    = irq_en_q;
            assign edge_word_s = {16'(irq_en_q), 16'(edge_q)};
        end else begin : g_no_irq_en
            assign irq_en_s    = {NUM_BTNS{1'b1}};
            assign edge_word_s = 32'(edge_q);
        end
    endgenerate

    // State registers with synchronous active-low reset
    always_ff @(posedge original_clk) begin
        if (!rst) begin
            out_q       <= {NUM_LEDS{1'b0}};
            blink_en_q  <= {NUM_LEDS{1'b0}};
            leds_q      <= {NUM_LEDS{1'b0}};
            blink_div_q <= {BLINK_DIV_W{1'b0}};
            presc_q     <= {BLINK_DIV_W{1'b0}};
            phase_q     <= 1'b0;
            meta_q      <= {NUM_BTNS{1'b0}};
            sync_q      <= {NUM_BTNS{1'b0}};
            stable_q    <= {NUM_BTNS{1'b0}};
            edge_q      <= {NUM_BTNS{1'b0}};
            for (int i = 0; i < NUM_BTNS; i++) begin
                db_cnt_q[i] <= {DB_W{1'b0}};
            end
            irq_q       <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            rvalid_q    <= 1'b0;
        end else begin
            out_q       <= out_d;
            blink_en_q  <= blink_en_d;
            leds_q      <= out_q & (~blink_en_q | {NUM_LEDS{phase_q}});
            blink_div_q <= blink_div_d;
            presc_q     <= presc_d;
            phase_q     <= phase_d;
            meta_q      <= btn;
            sync_q      <= meta_q;
            stable_q    <= stable_d;
            edge_q      <= edge_d;
            db_cnt_q    <= db_cnt_d;
            irq_q       <= |(edge_q & irq_en_s);
            rdata_q     <= rdata_d;
            rvalid_q    <= bus_re;
        end
    end

    assign leds       = leds_q;
    assign irq        = irq_q;
    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Self-checking bench for gpio_led_ctrl: table-driven LED writes, read scoreboard,
// blink period measurement and debounce/edge/irq corner sequences.
module tb_gpio_led_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic [0:0]  btn;
    logic [7:0]  leds;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb_q[$];
    logic        re_seen = 1'b0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  exp_leds;
    } vec_t;
    vec_t vecs[8];

    gpio_led_ctrl #(
        .NUM_LEDS(8), .NUM_BTNS(1), .DEBOUNCE_CYCLES(16), .BLINK_DIV_W(16)
    ) dut (
        .original_clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .btn(btn), .leds(leds), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        tick();
        bus_we    = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [31:0] exp);
        bus_addr = a;
        bus_re   = 1'b1;
        sb_q.push_back(exp);
        tick();
        bus_re   = 1'b0;
    endtask

    // Measures toggle spacing of leds[0] and confirms leds[1] stays lit
    task automatic measure_blink(input int exp_gap, input string name);
        logic prev;
        int   last;
        int   toggles;
        prev    = leds[0];
        last    = -1;
        toggles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check({name, "_led1"}, {31'd0, leds[1]}, 32'd1);
            if (leds[0] != prev) begin
                if (last >= 0) check({name, "_gap"}, i - last, exp_gap);
                last = i;
                toggles++;
            end
            prev = leds[0];
        end
        check({name, "_toggled"}, {31'd0, toggles >= 4}, 32'd1);
    endtask

    always @(posedge clk) re_seen <= bus_re;

    // Read scoreboard: rvalid must follow re by one cycle and data must match the queue head
    always @(negedge clk) begin
        if (re_seen || bus_rvalid) begin
            check("rvalid_timing", {31'd0, bus_rvalid}, {31'd0, re_seen});
            if (bus_rvalid) begin
                if (sb_q.size() == 0) begin
                    check("rdata_unexpected", bus_rdata, 32'hxxxx_xxxx);
                end else begin
                    check("rdata", bus_rdata, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd0, 32'h0000_00A5, 8'hA5};
        vecs[1] = '{3'd1, 32'h0000_000F, 8'hAF};
        vecs[2] = '{3'd2, 32'h0000_0081, 8'h2E};
        vecs[3] = '{3'd3, 32'h0000_00FF, 8'hD1};
        vecs[4] = '{3'd0, 32'hFFFF_FF00, 8'h00};
        vecs[5] = '{3'd1, 32'h0000_0180, 8'h80};
        vecs[6] = '{3'd3, 32'h0000_0081, 8'h01};
        vecs[7] = '{3'd2, 32'hFFFF_FFFF, 8'h00};

        rst = 1'b0; bus_addr = 3'd0; bus_wdata = 32'h0000_00FF;
        bus_we = 1'b1; bus_re = 1'b0; btn = 1'b0;
        repeat (3) tick();
        bus_we = 1'b0;
        rst    = 1'b1;
        check("reset_leds", {24'd0, leds}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_rvalid", {31'd0, bus_rvalid}, 32'd0);
        check("reset_rdata", bus_rdata, 32'd0);
        tick();
        check("reset_leds2", {24'd0, leds}, 32'd0);
        do_read(3'd0, 32'd0);
        tick();

        for (int i = 0; i < 8; i++) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
            tick();
            check($sformatf("leds_vec%0d", i), {24'd0, leds}, {24'd0, vecs[i].exp_leds});
        end
        bus_write(3'd1, 32'h0000_0055);
        do_read(3'd1, 32'd0);
        do_read(3'd0, 32'h0000_0055);
        tick();

        bus_write(3'd5, 32'd3);
        bus_write(3'd4, 32'h0000_0001);
        bus_write(3'd0, 32'h0000_0003);
        tick(); tick();
        measure_blink(4, "blink_div3");
        do_read(3'd5, 32'd3);
        bus_write(3'd5, 32'd0);
        tick(); tick();
        measure_blink(1, "blink_div0");
        bus_write(3'd4, 32'd0);
        tick();

        btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            do_read(3'd6, 32'd0);
            check("glitch_irq", {31'd0, irq}, 32'd0);
        end
        btn = 1'b0;
        for (int k = 0; k < 24; k++) begin
            do_read(3'd6, 32'd0);
            check("glitch_irq2", {31'd0, irq}, 32'd0);
        end
        do_read(3'd7, 32'd0);
        tick();

        btn = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            do_read(3'd6, (k >= 19) ? 32'd1 : 32'd0);
            check("noen_irq", {31'd0, irq}, 32'd0);
        end
        do_read(3'd7, 32'h0000_0001);
        bus_write(3'd7, 32'h0001_0000);
        check("irq_en_lat", {31'd0, irq}, 32'd0);
        tick();
        check("irq_en_rise", {31'd0, irq}, 32'd1);
        do_read(3'd7, 32'h0001_0001);

        btn = 1'b0;
        repeat (24) tick();
        do_read(3'd6, 32'd0);
        check("fall_irq", {31'd0, irq}, 32'd1);
        btn = 1'b1;
        repeat (17) tick();
        bus_write(3'd7, 32'h0001_0001);
        for (int k = 0; k < 3; k++) begin
            check("setwins_irq", {31'd0, irq}, 32'd1);
            tick();
        end
        do_read(3'd7, 32'h0001_0001);
        do_read(3'd6, 32'd1);
        bus_write(3'd7, 32'h0001_0001);
        check("w1c_irq_hold", {31'd0, irq}, 32'd1);
        tick();
        check("w1c_irq_drop", {31'd0, irq}, 32'd0);
        do_read(3'd7, 32'h0001_0000);
        bus_write(3'd6, 32'h0000_0000);
        do_read(3'd6, 32'd1);

        bus_write(3'd0, 32'h0000_0011);
        bus_addr  = 3'd0;
        bus_wdata = 32'h0000_003C;
        bus_we    = 1'b1;
        bus_re    = 1'b1;
        sb_q.push_back(32'h0000_0011);
        tick();
        bus_we = 1'b0;
        bus_re = 1'b0;
        do_read(3'd0, 32'h0000_003C);
        tick(); tick();
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_led_ctrl.md
Name: gpio_led_ctrl

Overview:
Parametrised memory-mapped LED/button peripheral that sits between the pipelined core's data-memory bus and the board pins. It replaces the fixed 8-bit LED latch and adds several features: per-channel set/clear/toggle writes, hardware blink with a programmable prescaler, and debounced button inputs. Each button has a sticky rising-edge flag and a maskable interrupt. All logic runs in the core clock domain.

Parameters:
NUM_LEDS, 8, LED output width (1..32)
NUM_BTNS, 1, button input count (1..32)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button change (>=1)
BLINK_DIV_W, 16, width of blink prescaler counter and BLINK_DIV register (1..32)

Ports:
original_clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset (0 = reset)
bus_addr  input  3  word index of register
bus_wdata  input  32  write data
bus_we  input  1  write strobe, one access per cycle
bus_re  input  1  read strobe
bus_rdata  output  32  read data
bus_rvalid  output  1  read data valid
btn  input  NUM_BTNS  raw asynchronous button pins
leds  output  NUM_LEDS  LED drive, registered
irq  output  1  level interrupt, registered

Behaviour:
- Reset (rst==0 at a clock edge): all registers, sync flops, debounce counters, prescaler and blink phase go to 0. Outputs leds=0, irq=0, bus_rdata=0, bus_rvalid=0. Reset takes priority over any bus access in the same cycle.
- Register map (word index), with unused bits reading 0:
  - 0 OUT, RW.
  - 1 SET, W: OUT |= wdata. Reads 0.
  - 2 CLR, W: OUT &= ~wdata. Reads 0.
  - 3 TOG, W: OUT ^= wdata. Reads 0.
  - 4 BLINK_EN, RW, NUM_LEDS bits.
  - 5 BLINK_DIV, RW, BLINK_DIV_W bits.
  - 6 BTN, RO: debounced button state. Writes are ignored.
  - 7 EDGE, W1C sticky rising-edge flags; bits [31:16] of this word also hold IRQ_EN (RW, NUM_BTNS<=16 in this case). If NUM_BTNS>16, IRQ_EN is absent and irq is the OR of EDGE.
- Bus writes: the register updates on the edge where bus_we=1. Only the low NUM_LEDS or NUM_BTNS bits of wdata are used.
- Bus reads: bus_rvalid=1 exactly one cycle after bus_re=1; otherwise 0. bus_rdata is registered and holds its value when rvalid=0.
- Read and write in the same cycle to the same register: the read returns the pre-write value.
- Blink prescaler: a free-running counter increments every cycle.
  - When counter==BLINK_DIV: counter resets to 0 and blink_phase toggles.
  - BLINK_DIV=0 toggles the phase every cycle. Period = 2*(BLINK_DIV+1) cycles.
  - A write to BLINK_DIV resets the counter to 0 and leaves the phase unchanged.
- LED output (registered, 1 cycle after a state change): leds[i] = OUT[i] & (~BLINK_EN[i] | blink_phase).
- Button path, per bit:
  - 2-flop synchroniser feeds a debounce counter.
  - When synced != stable, the counter increments. When synced == stable, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable takes the synced value and the counter clears.
  - Latency from pin change to BTN update: 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- EDGE[i] sets on the cycle stable[i] goes 0->1. It is cleared by writing 1 to that bit. If a set and a clear occur in the same cycle, the set wins.
- irq registered: irq = |(EDGE & IRQ_EN). It updates 1 cycle after EDGE or IRQ_EN changes.
- Same-cycle SET/CLR/TOG conflicts cannot occur (single-port bus).

Test Plan:
- Reset: hold rst=0 for 3 cycles with bus_we=1 to OUT, wdata=0xFF. Required: leds=0x00, irq=0, and a subsequent read of OUT gives 0 with rvalid exactly 1 cycle after re.
- Write OUT=0xA5, then SET 0x0F, then CLR 0x81, then TOG 0xFF. Required: leds = 0xA5 -> 0xAF -> 0x2E -> 0xD1, each 1 cycle after its write; a read of reg 1 returns 0.
- BLINK_DIV=3, BLINK_EN=0x01, OUT=0x03. Required: leds[0] toggles with period 8 cycles, leds[1] is constantly 1. Then BLINK_DIV=0: leds[0] alternates every cycle.
- DEBOUNCE_CYCLES=16. Pulse btn[0] high for 10 cycles: BTN, EDGE and irq stay 0. Then hold btn[0] high: BTN[0]=1 exactly 18 cycles after the rise and EDGE[0]=1; irq=1 one cycle later only if IRQ_EN[0]=1.
- With EDGE[0]=1 and IRQ_EN[0]=1, write 0x00010001 to reg 7 in the same cycle a new debounced rise occurs. Required: EDGE[0] remains 1 and irq stays 1. A later W1C with no edge clears EDGE[0] and drops irq on the next cycle.
- Read OUT in the same cycle as a write of 0x3C to OUT, starting from OUT=0x11. Required: rdata=0x11 with rvalid=1 on the next cycle; a subsequent read returns 0x3C.
